// File: rtl/ascon_result_capture.sv
// Result side of the Ascon data path: buffers ciphertext blocks and the final tag
// from ascon_top so the register block can drain them at its own pace.
module ascon_result_capture #(
  parameter int pDATA_WIDTH = 128,
  parameter int pDEPTH      = 4,
  parameter int pCNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            ct_valid_i,
  input  logic [pDATA_WIDTH-1:0]          ct_i,
  input  logic                            tag_ready_i,
  input  logic [63:0]                     tag1_i,
  input  logic [63:0]                     tag2_i,
  input  logic                            clear_i,
  input  logic                            pop_i,
  output logic [pDATA_WIDTH-1:0]          pop_data_o,
  output logic                            pop_valid_o,
  output logic                            empty_o,
  output logic                            full_o,
  output logic [$clog2(pDEPTH):0]         level_o,
  output logic                            overflow_o,
  output logic                            err_o,
  output logic [127:0]                    tag_o,
  output logic                            tag_valid_o,
  output logic [pCNT_WIDTH-1:0]           blk_count_o,
  output logic                            busy_o
);

  localparam int PTR_W = $clog2(pDEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t                   state_reg, state_next;
  logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]         level_reg, level_next;
  logic [pCNT_WIDTH-1:0]    blk_count_reg, blk_count_next;
  logic [pDATA_WIDTH-1:0]   pop_data_reg;
  logic                     pop_valid_reg;
  logic                     overflow_reg;
  logic                     err_reg;
  logic [127:0]             tag_reg;
  logic                     tag_valid_reg;

  logic [pDATA_WIDTH-1:0]   mem [pDEPTH];

  logic fifo_full, fifo_empty;
  logic accept_ct, do_push, do_pop, drop_full, underflow;
  logic late_ct, late_tag, tag_take, err_event;

  assign fifo_full  = (level_reg == LVL_W'(pDEPTH));
  assign fifo_empty = (level_reg == '0);

  // clear_i masks every other request in its cycle
  assign accept_ct = ct_valid_i && !clear_i && (state_reg != COMPLETE);
  assign do_pop    = pop_i && !clear_i && !fifo_empty;
  assign do_push   = accept_ct && (!fifo_full || do_pop);
  assign drop_full = accept_ct && fifo_full && !do_pop;
  assign underflow = pop_i && !clear_i && fifo_empty && !do_push;
  assign late_ct   = ct_valid_i && !clear_i && (state_reg == COMPLETE);
  assign late_tag  = tag_ready_i && !clear_i && (state_reg == COMPLETE);
  assign tag_take  = tag_ready_i && !clear_i && (state_reg != COMPLETE);
  assign err_event = underflow || late_ct || late_tag;

  always_comb begin
    state_next = state_reg;
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (tag_ready_i)     state_next = COMPLETE;
          else if (ct_valid_i) state_next = COLLECT;
        end
        COLLECT: begin
          if (tag_ready_i) state_next = COMPLETE;
        end
        COMPLETE: state_next = COMPLETE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    level_next = level_reg;
    case ({do_push, do_pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // counter sticks at all-ones instead of wrapping
  always_comb begin
    blk_count_next = blk_count_reg;
    if (do_push && (blk_count_reg != '1))
      blk_count_next = blk_count_reg + pCNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= ct_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      blk_count_reg <= '0;
      pop_data_reg  <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      err_reg       <= 1'b0;
      tag_reg       <= '0;
      tag_valid_reg <= 1'b0;
    end else if (clear_i) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      blk_count_reg <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      err_reg       <= 1'b0;
      tag_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      blk_count_reg <= blk_count_next;
      pop_valid_reg <= do_pop;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      // read-before-write keeps the oldest block correct on a full push+pop
      if (do_pop) begin
        rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
        pop_data_reg <= mem[rd_ptr_reg];
      end
      if (drop_full) overflow_reg <= 1'b1;
      if (err_event) err_reg <= 1'b1;
      if (tag_take) begin
        tag_reg       <= {tag2_i, tag1_i};
        tag_valid_reg <= 1'b1;
      end
    end
  end

  assign pop_data_o  = pop_data_reg;
  assign pop_valid_o = pop_valid_reg;
  assign empty_o     = fifo_empty;
  assign full_o      = fifo_full;
  assign level_o     = level_reg;
  assign overflow_o  = overflow_reg;
  assign err_o       = err_reg;
  assign tag_o       = tag_reg;
  assign tag_valid_o = tag_valid_reg;
  assign blk_count_o = blk_count_reg;
  assign busy_o      = (state_reg == COLLECT);

endmodule

// File: tb/tb_ascon_result_capture.sv
// Directed bench for ascon_result_capture: hand-computed vectors checked by immediate assertions.
module tb_ascon_result_capture;

  logic           clk;
  logic           reset_n;
  logic           ct_valid_i;
  logic [127:0]   ct_i;
  logic           tag_ready_i;
  logic [63:0]    tag1_i;
  logic [63:0]    tag2_i;
  logic           clear_i;
  logic           pop_i;
  logic [127:0]   pop_data_o;
  logic           pop_valid_o;
  logic           empty_o;
  logic           full_o;
  logic [2:0]     level_o;
  logic           overflow_o;
  logic           err_o;
  logic [127:0]   tag_o;
  logic           tag_valid_o;
  logic [15:0]    blk_count_o;
  logic           busy_o;

  int vectors;
  int miscompares;

  ascon_result_capture #(
    .pDATA_WIDTH(128),
    .pDEPTH(4),
    .pCNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ct_valid_i(ct_valid_i),
    .ct_i(ct_i),
    .tag_ready_i(tag_ready_i),
    .tag1_i(tag1_i),
    .tag2_i(tag2_i),
    .clear_i(clear_i),
    .pop_i(pop_i),
    .pop_data_o(pop_data_o),
    .pop_valid_o(pop_valid_o),
    .empty_o(empty_o),
    .full_o(full_o),
    .level_o(level_o),
    .overflow_o(overflow_o),
    .err_o(err_o),
    .tag_o(tag_o),
    .tag_valid_o(tag_valid_o),
    .blk_count_o(blk_count_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s observed %0h expected %0h", vectors, tag, obs, exp);
  endtask

  // one clock edge, outputs sampled 1 ns later, pulse inputs dropped
  task automatic step();
    @(posedge clk);
    #1;
    ct_valid_i  = 1'b0;
    tag_ready_i = 1'b0;
    clear_i     = 1'b0;
    pop_i       = 1'b0;
  endtask

  task automatic push(input logic [127:0] d);
    ct_valid_i = 1'b1;
    ct_i       = d;
    step();
  endtask

  task automatic pop_expect(input string tag, input logic [127:0] d);
    pop_i = 1'b1;
    step();
    check({tag, "_valid"}, 128'(pop_valid_o), 128'd1);
    check({tag, "_data"}, pop_data_o, d);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    ct_valid_i  = 1'b0;
    ct_i        = '0;
    tag_ready_i = 1'b0;
    tag1_i      = '0;
    tag2_i      = '0;
    clear_i     = 1'b0;
    pop_i       = 1'b0;

    // reset values
    #12;
    check("rst_empty", 128'(empty_o), 128'd1);
    check("rst_level", 128'(level_o), 128'd0);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_tag", tag_o, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // 1: three blocks then tag, drain in order
    push(128'h01);
    check("t1_busy", 128'(busy_o), 128'd1);
    push(128'h02);
    push(128'h03);
    check("t1_level_pre", 128'(level_o), 128'd3);
    tag2_i      = 64'hAAAA_AAAA_AAAA_AAAA;
    tag1_i      = 64'h5555_5555_5555_5555;
    tag_ready_i = 1'b1;
    step();
    check("t1_level", 128'(level_o), 128'd3);
    check("t1_blk", 128'(blk_count_o), 128'd3);
    check("t1_tag", tag_o, 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555);
    check("t1_tagv", 128'(tag_valid_o), 128'd1);
    check("t1_busy_done", 128'(busy_o), 128'd0);
    pop_expect("t1_pop0", 128'h01);
    pop_expect("t1_pop1", 128'h02);
    pop_expect("t1_pop2", 128'h03);
    check("t1_empty", 128'(empty_o), 128'd1);
    step();
    check("t1_pv_low", 128'(pop_valid_o), 128'd0);
    check("t1_hold", pop_data_o, 128'h03);

    // 2: overflow on the fifth push
    do_clear();
    check("t2_clr_tagv", 128'(tag_valid_o), 128'd0);
    check("t2_clr_tag", tag_o, 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555);
    for (int i = 0; i < 4; i++) push(128'h10 + 128'(i));
    check("t2_full4", 128'(full_o), 128'd1);
    check("t2_ovf_pre", 128'(overflow_o), 128'd0);
    push(128'h14);
    check("t2_ovf", 128'(overflow_o), 128'd1);
    check("t2_level", 128'(level_o), 128'd4);
    check("t2_blk", 128'(blk_count_o), 128'd4);
    for (int i = 0; i < 4; i++) pop_expect("t2_pop", 128'h10 + 128'(i));
    check("t2_empty", 128'(empty_o), 128'd1);

    // 3: full, push and pop together
    do_clear();
    for (int i = 0; i < 4; i++) push(128'h20 + 128'(i));
    ct_valid_i = 1'b1;
    ct_i       = 128'h24;
    pop_i      = 1'b1;
    step();
    check("t3_pv", 128'(pop_valid_o), 128'd1);
    check("t3_data", pop_data_o, 128'h20);
    check("t3_level", 128'(level_o), 128'd4);
    check("t3_ovf", 128'(overflow_o), 128'd0);
    check("t3_blk", 128'(blk_count_o), 128'd5);
    for (int i = 1; i < 5; i++) pop_expect("t3_pop", 128'h20 + 128'(i));

    // 4: underflow, then push+pop while empty
    check("t4_err_pre", 128'(err_o), 128'd0);
    pop_i = 1'b1;
    step();
    check("t4_pv", 128'(pop_valid_o), 128'd0);
    check("t4_err", 128'(err_o), 128'd1);
    do_clear();
    ct_valid_i = 1'b1;
    ct_i       = 128'h33;
    pop_i      = 1'b1;
    step();
    check("t4_lvl1", 128'(level_o), 128'd1);
    check("t4_err_keep", 128'(err_o), 128'd0);
    check("t4_pv_none", 128'(pop_valid_o), 128'd0);
    pop_expect("t4_pop", 128'h33);

    // 5: empty message, late block and second tag
    do_clear();
    tag2_i      = 64'h0123_4567_89AB_CDEF;
    tag1_i      = 64'hFEDC_BA98_7654_3210;
    tag_ready_i = 1'b1;
    step();
    check("t5_tagv", 128'(tag_valid_o), 128'd1);
    check("t5_busy", 128'(busy_o), 128'd0);
    check("t5_blk", 128'(blk_count_o), 128'd0);
    check("t5_err_pre", 128'(err_o), 128'd0);
    push(128'h44);
    check("t5_err", 128'(err_o), 128'd1);
    check("t5_level", 128'(level_o), 128'd0);
    do_clear();
    tag_ready_i = 1'b1;
    step();
    tag2_i      = 64'h1111_1111_1111_1111;
    tag1_i      = 64'h2222_2222_2222_2222;
    tag_ready_i = 1'b1;
    step();
    check("t5_tag_keep", tag_o, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    check("t5_err2", 128'(err_o), 128'd1);

    // 6: clear with push+pop pending, then async reset mid-message
    do_clear();
    push(128'h30);
    push(128'h31);
    check("t6_lvl2", 128'(level_o), 128'd2);
    clear_i    = 1'b1;
    ct_valid_i = 1'b1;
    ct_i       = 128'h32;
    pop_i      = 1'b1;
    step();
    check("t6_level", 128'(level_o), 128'd0);
    check("t6_empty", 128'(empty_o), 128'd1);
    check("t6_pv", 128'(pop_valid_o), 128'd0);
    check("t6_blk", 128'(blk_count_o), 128'd0);
    check("t6_busy", 128'(busy_o), 128'd0);
    push(128'h40);
    push(128'h41);
    pop_expect("t6_pop", 128'h40);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6r_data", pop_data_o, 128'd0);
    check("t6r_level", 128'(level_o), 128'd0);
    check("t6r_empty", 128'(empty_o), 128'd1);
    check("t6r_blk", 128'(blk_count_o), 128'd0);
    check("t6r_busy", 128'(busy_o), 128'd0);
    check("t6r_tag", tag_o, 128'd0);
    check("t6r_pv", 128'(pop_valid_o), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
